// File: rtl/fetch_buffer_if.sv
// ============================================================================
// Module   : fetch_buffer_if
// Brief    : Memory-side, redirect and decode-side signals of the fetch buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_buffer_if #(
  parameter int NBITS = 32,
  parameter int DEPTH = 4
);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic               imem_req;
  logic [NBITS-1:0]   imem_addr;
  logic [NBITS-1:0]   imem_rdata;
  logic               imem_rvalid;
  logic               redirect;
  logic [NBITS-1:0]   redirect_pc;
  logic               id_ready;
  logic               id_valid;
  logic [NBITS-1:0]   id_instr;
  logic [NBITS-1:0]   id_pc;
  logic [c_cnt_w-1:0] count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_rvalid,
    input  redirect, redirect_pc, id_ready,
    output id_valid, id_instr, id_pc, count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_rvalid,
    output redirect, redirect_pc, id_ready,
    input  id_valid, id_instr, id_pc, count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Credit-limited instruction fetch queue with redirect flush.
//            Define FETCH_BUFFER_BYPASS_EN for a zero-latency empty bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
  parameter int               NBITS    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [NBITS-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  fetch_buffer_if.master bus
);
  localparam int c_pw = $clog2(DEPTH);
  localparam int c_cw = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_fetch_pc;
  logic [NBITS-1:0] r_req_pc;
  logic             r_inflight;
  logic [c_pw-1:0]  r_head;
  logic [c_pw-1:0]  r_tail;
  logic [c_cw-1:0]  r_count;
  logic [NBITS-1:0] r_mem_instr [DEPTH];
  logic [NBITS-1:0] r_mem_pc    [DEPTH];

  logic             w_req;
  logic             w_flush;
  logic             w_nonempty;
  logic             w_resp_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [NBITS-1:0] w_instr;
  logic [NBITS-1:0] w_pc;
  logic [c_cw:0]    w_occ;

  assign w_occ      = {1'b0, r_count} + {{c_cw{1'b0}}, r_inflight};
  assign w_nonempty = (r_count != '0);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.redirect) begin
          w_state_nxt = ST_FLUSH;
          w_flush     = 1'b1;
        end else begin
          w_req = (w_occ < (c_cw + 1)'(DEPTH));
        end
      end
      ST_FLUSH: begin
        if (bus.redirect) begin
          w_flush = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Only a response to a request issued from RUN, not killed this cycle, counts.
  assign w_resp_ok = bus.imem_rvalid & r_inflight & (r_state == ST_RUN) & ~bus.redirect;
  assign w_pop     = w_nonempty & bus.id_ready & ~bus.redirect;

`ifdef FETCH_BUFFER_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_resp_ok & ~w_nonempty;
  assign w_valid  = w_nonempty | w_bypass;
  assign w_instr  = w_bypass ? bus.imem_rdata : r_mem_instr[r_head];
  assign w_pc     = w_bypass ? r_req_pc : r_mem_pc[r_head];
  assign w_push   = w_resp_ok & ~(w_bypass & bus.id_ready);
`else
  assign w_valid  = w_nonempty;
  assign w_instr  = r_mem_instr[r_head];
  assign w_pc     = r_mem_pc[r_head];
  assign w_push   = w_resp_ok;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_req;
      if (w_req) begin
        r_req_pc <= r_fetch_pc;
      end
      if (bus.redirect) begin
        r_fetch_pc <= bus.redirect_pc;
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + NBITS'(4);
      end
      if (w_flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + c_pw'(1);
        end
        if (w_pop) begin
          r_head <= r_head + c_pw'(1);
        end
        r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_tail] <= bus.imem_rdata;
      r_mem_pc[r_tail]    <= r_req_pc;
    end
  end

  assign bus.imem_req  = w_req;
  assign bus.imem_addr = r_fetch_pc;
  assign bus.id_valid  = w_valid;
  assign bus.id_instr  = w_instr;
  assign bus.id_pc     = w_pc;
  assign bus.count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Directed scoreboard bench for fetch_buffer with a 1-cycle memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;
  localparam logic [31:0] c_reset_pc = 32'h100;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [31:0] exp_pc;
  logic        s_req;
  logic [31:0] s_addr;

  fetch_buffer_if #(.NBITS(32), .DEPTH(4)) bus ();

  fetch_buffer #(
    .NBITS   (32),
    .DEPTH   (4),
    .RESET_PC(c_reset_pc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard on the falling edge, memory response just after the rise.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    if (!rst) begin
      q.delete();
      exp_pc = c_reset_pc;
    end else begin
      if (s_req) begin
        check("req_addr", s_addr, exp_pc);
        q.push_back('{instr_of(s_addr), s_addr});
        exp_pc = exp_pc + 32'd4;
      end
      if (bus.redirect) begin
        check("req_during_redirect", {31'b0, s_req}, 32'd0);
        q.delete();
        exp_pc = bus.redirect_pc;
      end else if (bus.id_valid && bus.id_ready) begin
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL pop_unexpected observed=%0h expected=none", bus.id_pc);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          check("pop_instr", bus.id_instr, e.instr);
          check("pop_pc", bus.id_pc, e.pc);
        end
      end
    end
    @(posedge clk);
    #1;
    bus.imem_rvalid = s_req;
    bus.imem_rdata  = instr_of(s_addr);
    #1;
  endtask

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b1;
    exp_pc          = c_reset_pc;

    // Reset and the BOOT cycle
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    tick();
    check("first_req", {31'b0, bus.imem_req}, 32'd1);
    check("first_addr", bus.imem_addr, 32'h100);
    tick();
`ifdef FETCH_BUFFER_BYPASS_EN
    check("byp_valid", {31'b0, bus.id_valid}, 32'd1);
    check("byp_instr", bus.id_instr, 32'h0000_0013);
    check("byp_pc", bus.id_pc, 32'h100);
    check("byp_count", 32'(bus.count), 32'd0);
`else
    check("lat1_valid", {31'b0, bus.id_valid}, 32'd0);
`endif
    check("second_addr", bus.imem_addr, 32'h104);
    tick();
`ifndef FETCH_BUFFER_BYPASS_EN
    check("lat2_valid", {31'b0, bus.id_valid}, 32'd1);
    check("lat2_pc", bus.id_pc, 32'h100);
    check("lat2_count", 32'(bus.count), 32'd1);
`endif
    check("third_addr", bus.imem_addr, 32'h108);
    repeat (6) tick();

    // Decode stall: saturate, then free exactly one slot
    bus.id_ready = 1'b0;
    repeat (10) tick();
    check("sat_count", 32'(bus.count), 32'd4);
    check("sat_req", {31'b0, bus.imem_req}, 32'd0);
    check("sat_valid", {31'b0, bus.id_valid}, 32'd1);
    bus.id_ready = 1'b1;
    tick();
    check("pop1_count", 32'(bus.count), 32'd3);
    check("pop1_req", {31'b0, bus.imem_req}, 32'd1);
    bus.id_ready = 1'b0;
    tick();
    check("c3i1_count", 32'(bus.count), 32'd3);
    check("c3i1_req", {31'b0, bus.imem_req}, 32'd0);

    // Redirect with three buffered and one in flight
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    #1;
    check("redir_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_valid", {31'b0, bus.id_valid}, 32'd0);
    check("flush_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check("restart_req", {31'b0, bus.imem_req}, 32'd1);
    check("restart_addr", bus.imem_addr, 32'h200);
    bus.id_ready = 1'b1;
    repeat (6) tick();

    // Redirect again while already flushing
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_pc = 32'h300;
    #1;
    check("reflush_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    bus.redirect = 1'b0;
    #1;
    check("reflush2_req", {31'b0, bus.imem_req}, 32'd0);
    check("reflush2_count", 32'(bus.count), 32'd0);
    tick();
    check("r300_req", {31'b0, bus.imem_req}, 32'd1);
    check("r300_addr", bus.imem_addr, 32'h300);
    bus.id_ready = 1'b0;
    tick();
    tick();
    check("r300_valid", {31'b0, bus.id_valid}, 32'd1);
    check("r300_pc", bus.id_pc, 32'h300);
    check("r300_count", 32'(bus.count), 32'd1);
    tick();
    check("pre_rst_count", 32'(bus.count), 32'd2);

    // Mid-stream reset; the response landing in BOOT must be dropped
    rst = 1'b0;
    tick();
    check("mrst_valid", {31'b0, bus.id_valid}, 32'd0);
    check("mrst_count", 32'(bus.count), 32'd0);
    rst = 1'b1;
    #1;
    check("boot_valid", {31'b0, bus.id_valid}, 32'd0);
    check("boot_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    check("post_boot_count", 32'(bus.count), 32'd0);
    check("post_boot_req", {31'b0, bus.imem_req}, 32'd1);
    check("post_boot_addr", bus.imem_addr, c_reset_pc);
    bus.id_ready = 1'b1;
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 The block SHALL have parameter NBITS, default 32: instruction and address width.
REQ-002 The block SHALL have parameter DEPTH, default 4: queue entries, a power of two, at least 2.
REQ-003 The block SHALL have parameter RESET_PC, default 0: first fetch address after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-007 The block SHALL have port imem_addr, output, NBITS: fetch address.
REQ-008 The block SHALL have port imem_rdata, input, NBITS: fetched instruction.
REQ-009 The block SHALL have port imem_rvalid, input, 1 bit: response valid, exactly 1 cycle after imem_req.
REQ-010 The block SHALL have port redirect, input, 1 bit: branch or jump taken; flushes the buffer.
REQ-011 The block SHALL have port redirect_pc, input, NBITS: new fetch address.
REQ-012 The block SHALL have port id_ready, input, 1 bit: decode accepts (the IF/ID enable from hazard detection); low means stall.
REQ-013 The block SHALL have port id_valid, output, 1 bit: head entry valid.
REQ-014 The block SHALL have port id_instr, output, NBITS: head instruction.
REQ-015 The block SHALL have port id_pc, output, NBITS: PC of the head instruction.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH+1) bits: occupied entries.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and FLUSH; reset SHALL enter BOOT.
REQ-018 BOOT SHALL last 1 cycle with imem_req=0 and then go to RUN.
REQ-019 In RUN, imem_req SHALL be 1 when count + inflight < DEPTH, where inflight is the registered imem_req of the previous cycle.
REQ-020 imem_addr SHALL equal fetch_pc, and fetch_pc SHALL advance by 4 on each issued request, wrapping modulo 2^NBITS.
REQ-021 A response with imem_rvalid=1, when not killed, SHALL push {imem_rdata, issuing PC} at the tail; each request SHALL be tagged with its PC.
REQ-022 A pop SHALL occur when id_valid and id_ready are both high, and the head pointer SHALL advance.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-024 A simultaneous push and pop SHALL leave count unchanged.
REQ-025 The credit rule in REQ-019 SHALL make overflow impossible.
REQ-026 A pop while empty SHALL be ignored.
REQ-027 id_instr and id_pc SHALL be don't-care while id_valid=0.
REQ-028 On redirect=1, in any state except BOOT:
- count, head and tail SHALL clear the next cycle;
- fetch_pc SHALL load redirect_pc;
- imem_req SHALL be 0 in that cycle;
- the FSM SHALL go to FLUSH.
REQ-029 FLUSH SHALL drop any response arriving in it (a killed in-flight request), keep imem_req=0, and return to RUN after 1 cycle.
REQ-030 A redirect during FLUSH SHALL reload fetch_pc and stay in FLUSH for 1 more cycle.
REQ-031 redirect SHALL take priority over a same-cycle pop or push; neither is committed.
REQ-032 A redirect in BOOT SHALL load fetch_pc and have no other effect.
REQ-033 id_valid SHALL be 0 whenever count=0, except as given in REQ-038.

Reset
REQ-034 When rst=0 at a clock edge, the block SHALL set: state=BOOT, fetch_pc=RESET_PC, count=0, pointers=0, inflight=0.
REQ-035 After reset, the outputs SHALL be imem_req=0, id_valid=0 and count=0.
REQ-036 Reset SHALL override redirect and all in-progress transfers.
REQ-037 A response arriving the cycle after reset deasserts SHALL be dropped.

Configuration
REQ-038 With macro FETCH_BUFFER_BYPASS_EN defined, when count=0 and imem_rvalid=1 for a response that is not killed:
- id_valid SHALL be 1 in the same cycle, with id_instr=imem_rdata and the tagged PC;
- if id_ready=1, the entry SHALL NOT be written, giving 0-cycle latency.
REQ-039 Without FETCH_BUFFER_BYPASS_EN, every response SHALL be written first and appear on id_* no earlier than 1 cycle after imem_rvalid.

Verification
REQ-040 Reset, RESET_PC=0x100, id_ready=1, 1-cycle memory -> imem_addr sequence 0x100, 0x104, 0x108; id_pc in the same order; without bypass, first id_valid 2 cycles after the first imem_req.
REQ-041 id_ready=0 with DEPTH=4 -> count saturates at 4, imem_req=0 while count+inflight=4, no loss; releasing id_ready drains 4 entries in order.
REQ-042 redirect=1 with redirect_pc=0x200 while count=3 and 1 inflight -> next cycle count=0 and the inflight response is dropped; the next imem_addr=0x200 two cycles after redirect.
REQ-043 redirect asserted in FLUSH with 0x300 -> fetch restarts at 0x300 and no instruction from 0x200 is presented.
REQ-044 rst=0 mid-stream with count=2 -> next cycle id_valid=0, count=0; fetch resumes at RESET_PC after the BOOT cycle.
REQ-045 With FETCH_BUFFER_BYPASS_EN, an empty buffer and a response of 0x00000013 with id_ready=1 -> id_valid=1 and id_instr=0x00000013 in the same cycle, and count stays 0.
